// File: rtl/cache_lru_tree.sv
// -----------------------------------------------------------------------------
// cache_lru_tree
//
// Tree pseudo-LRU replacement tracker for a set-associative cache. Each set
// holds NUM_WAYS-1 heap-ordered tree bits (node 1 is the root, the children of
// node n are 2n and 2n+1, and the leaves are the ways in ascending order). A
// bit of 0 points the LRU side at the lower half; a bit of 1 points it at the
// upper half. Fills get the victim one cycle after the request and mark it
// MRU. Access hits mark the reported way MRU one cycle after the lookup.
//
// Ports
//   clk                in   clock, all state updates on the rising edge
//   reset              in   asynchronous active-low reset
//   fill_en            in   fill requested for fill_set
//   fill_set           in   set being filled
//   fill_way           out  victim way for the fill issued the previous cycle
//   access_en          in   pipeline lookup of access_set
//   access_set         in   set being accessed
//   access_update_en   in   previous access hit, mark access_update_way MRU
//   access_update_way  in   way that hit
// -----------------------------------------------------------------------------
module cache_lru_tree #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4,
  localparam int SET_INDEX_WIDTH = $clog2(NUM_SETS),
  localparam int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_en,
  input  logic [SET_INDEX_WIDTH-1:0] fill_set,
  output logic [WAY_INDEX_WIDTH-1:0] fill_way,
  input  logic                       access_en,
  input  logic [SET_INDEX_WIDTH-1:0] access_set,
  input  logic                       access_update_en,
  input  logic [WAY_INDEX_WIDTH-1:0] access_update_way
);

  // Tree depth and storage width; a 1-way cache keeps a single unused bit so
  // the storage never has zero width.
  localparam int LVL    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 0;
  localparam int TREE_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

  // Node n is stored at bit n-1.
  function automatic logic [WAY_INDEX_WIDTH-1:0] victim_of(input logic [TREE_W-1:0] bits);
    int               node;
    logic [TREE_W-1:0] sh;
    node = 1;
    for (int l = 0; l < LVL; l++) begin
      sh   = bits >> (node - 1);
      node = 2 * node + int'(sh[0]);
    end
    return WAY_INDEX_WIDTH'(node - NUM_WAYS);
  endfunction

  // Every node on the path to way w is made to point at the other subtree.
  function automatic logic [TREE_W-1:0] touch_of(input logic [TREE_W-1:0]          bits,
                                                  input logic [WAY_INDEX_WIDTH-1:0] w);
    logic [TREE_W-1:0] r;
    logic [TREE_W-1:0] mask;
    int                leaf;
    int                node;
    int                dir;
    r    = bits;
    leaf = int'(w) + NUM_WAYS;
    node = 1;
    for (int l = 0; l < LVL; l++) begin
      dir  = (leaf >> (LVL - 1 - l)) & 1;
      mask = TREE_W'(1) << (node - 1);
      if (dir != 0) r = r & ~mask;
      else          r = r | mask;
      node = 2 * node + dir;
    end
    return r;
  endfunction

  logic [TREE_W-1:0]          tree_q [NUM_SETS];

  logic                       fill_vld_p1;
  logic [SET_INDEX_WIDTH-1:0] fill_set_p1;
  logic [TREE_W-1:0]          fill_bits_p1;
  logic [SET_INDEX_WIDTH-1:0] acc_set_p1;

  logic                       wr_en;
  logic [SET_INDEX_WIDTH-1:0] wr_set;
  logic [TREE_W-1:0]          wr_bits;
  logic [TREE_W-1:0]          fill_rd;

  // ---- stage p1: victim out, tree write-back ----
  assign fill_way = victim_of(fill_bits_p1);

  // A pending fill touch always wins the single write port. The access touch
  // is applied to the set's current bits so that a late update after an
  // intervening fill to the same set does not undo that fill's touch.
  always_comb begin
    wr_en   = 1'b0;
    wr_set  = fill_set_p1;
    wr_bits = touch_of(fill_bits_p1, victim_of(fill_bits_p1));
    if (fill_vld_p1) begin
      wr_en = 1'b1;
    end else if (access_update_en) begin
      wr_en   = 1'b1;
      wr_set  = acc_set_p1;
      wr_bits = touch_of(tree_q[acc_set_p1], access_update_way);
    end
  end

  // ---- stage p0: set read with write bypass ----
  always_comb begin
    fill_rd = tree_q[fill_set];
    if (wr_en && (wr_set == fill_set)) fill_rd = wr_bits;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_vld_p1  <= 1'b0;
      fill_set_p1  <= '0;
      fill_bits_p1 <= '0;
      acc_set_p1   <= '0;
    end else begin
      fill_vld_p1 <= fill_en;
      if (fill_en) begin
        fill_set_p1  <= fill_set;
        fill_bits_p1 <= fill_rd;
      end
      if (access_en) acc_set_p1 <= access_set;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
    end else if (wr_en) begin
      tree_q[wr_set] <= wr_bits;
    end
  end

endmodule

// File: tb/tb_cache_lru_tree.sv
module tb_cache_lru_tree;

  localparam int NW = 4;
  localparam int NS = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       fill_en = 1'b0;
  logic [5:0] fill_set = '0;
  logic [1:0] fill_way;
  logic       access_en = 1'b0;
  logic [5:0] access_set = '0;
  logic       access_update_en = 1'b0;
  logic [1:0] access_update_way = '0;

  logic       f8_en = 1'b0;
  logic [1:0] f8_set = '0;
  logic [2:0] w8;
  logic [1:0] z8_set = '0;
  logic [2:0] z8_way = '0;
  logic       f2_en = 1'b0;
  logic       f2_set = 1'b0;
  logic       w2;
  logic       z2_set = 1'b0;
  logic       z2_way = 1'b0;
  logic       zero = 1'b0;

  int checks = 0;
  int failures = 0;

  cache_lru_tree #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk(clk), .reset(reset),
    .fill_en(fill_en), .fill_set(fill_set), .fill_way(fill_way),
    .access_en(access_en), .access_set(access_set),
    .access_update_en(access_update_en), .access_update_way(access_update_way)
  );

  cache_lru_tree #(.NUM_SETS(4), .NUM_WAYS(8)) dut8 (
    .clk(clk), .reset(reset),
    .fill_en(f8_en), .fill_set(f8_set), .fill_way(w8),
    .access_en(zero), .access_set(z8_set),
    .access_update_en(zero), .access_update_way(z8_way)
  );

  cache_lru_tree #(.NUM_SETS(2), .NUM_WAYS(2)) dut2 (
    .clk(clk), .reset(reset),
    .fill_en(f2_en), .fill_set(f2_set), .fill_way(w2),
    .access_en(zero), .access_set(z2_set),
    .access_update_en(zero), .access_update_way(z2_way)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: bit n of m_tree[s] is tree node n (bit 0 unused).
  bit [7:0]   m_tree [NS];
  bit         m_fvld;
  int         m_fset;
  bit [7:0]   m_fbits;
  int         m_aset;
  int         exp_q[$];

  function automatic int m_victim(input bit [7:0] b);
    int n = 1;
    while (n < NW) n = 2 * n + int'(b[n]);
    return n - NW;
  endfunction

  // Walk from the leaf up; a left child makes its parent point right.
  function automatic bit [7:0] m_touch(input bit [7:0] b, input int w);
    bit [7:0] r = b;
    int n = w + NW;
    while (n > 1) begin
      r[n / 2] = (n % 2 == 0);
      n = n / 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < NS; s++) m_tree[s] = '0;
    m_fvld = 0; m_fset = 0; m_fbits = '0; m_aset = 0;
  endtask

  // Entered and left at posedge+1; inputs must already be driven.
  task automatic step();
    bit       n_fvld;
    int       n_fset;
    bit [7:0] n_fbits;
    int       n_aset;
    @(negedge clk);
    if (m_fvld) begin
      chk("fill_way_model", 32'(fill_way), 32'(m_victim(m_fbits)));
      if (exp_q.size() > 0) chk("fill_way_directed", 32'(fill_way), 32'(exp_q.pop_front()));
      m_tree[m_fset] = m_touch(m_fbits, m_victim(m_fbits));
    end else if (access_update_en) begin
      m_tree[m_aset] = m_touch(m_tree[m_aset], int'(access_update_way));
    end
    n_fvld  = fill_en;
    n_fset  = fill_en ? int'(fill_set) : m_fset;
    n_fbits = fill_en ? m_tree[fill_set] : m_fbits;
    n_aset  = access_en ? int'(access_set) : m_aset;
    @(posedge clk);
    m_fvld = n_fvld; m_fset = n_fset; m_fbits = n_fbits; m_aset = n_aset;
    #1;
  endtask

  task automatic idle_inputs();
    fill_en = 0; access_en = 0; access_update_en = 0;
  endtask

  // Asserted mid-cycle to exercise the asynchronous clear.
  task automatic do_reset();
    idle_inputs();
    reset = 0;
    #1;
    chk("reset_fill_way", 32'(fill_way), 32'd0);
    model_clear();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int s, input int exp);
    fill_en = 1; fill_set = 6'(s);
    exp_q.push_back(exp);
    step();
    fill_en = 0;
  endtask

  int seq8[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int rot[5]  = '{0, 2, 1, 3, 0};

  initial begin
    model_clear();
    @(posedge clk); #1;
    chk("reset_hold_fill_way", 32'(fill_way), 32'd0);
    do_reset();

    // Other geometries from reset.
    f8_en = 1; f2_en = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("ways8_seq", 32'(w8), 32'(seq8[i-1]));
        chk("ways2_seq", 32'(w2), 32'((i - 1) % 2));
      end
      @(posedge clk); #1;
    end
    f8_en = 0; f2_en = 0;
    @(negedge clk);
    chk("ways8_seq", 32'(w8), 32'(seq8[7]));
    chk("ways2_seq", 32'(w2), 32'd1);
    @(posedge clk); #1;
    do_reset();

    // Reset victims.
    fill(5, 0); step();
    fill(0, 0);
    fill(63, 0); step();

    // Back-to-back rotation on one set.
    for (int i = 0; i < 5; i++) fill(3, rot[i]);
    step();

    // Hit on way 0 then fill.
    do_reset();
    access_en = 1; access_set = 7; step();
    access_en = 0; access_update_en = 1; access_update_way = 0; step();
    access_update_en = 0;
    fill(7, 2); step();

    // Hit on way 2 then fill.
    do_reset();
    access_en = 1; access_set = 7; step();
    access_en = 0; access_update_en = 1; access_update_way = 2; step();
    access_update_en = 0;
    fill(7, 0); step();

    // Collision: fill touch wins over access touch.
    do_reset();
    fill_en = 1; fill_set = 9; access_en = 1; access_set = 9; exp_q.push_back(0); step();
    fill_en = 0; access_en = 0; access_update_en = 1; access_update_way = 3; step();
    access_update_en = 0;
    fill(9, 2); step();

    // Set isolation: updates to set 1 (second one sticky) leave set 2 alone.
    do_reset();
    access_en = 1; access_set = 1; step();
    access_en = 0; access_update_en = 1; access_update_way = 1; step();
    access_update_way = 3; step();
    access_update_en = 0;
    for (int i = 0; i < 4; i++) fill(2, rot[i]);
    step();

    // Mid-stream reset clears a touched set.
    fill(4, 0);
    fill(4, 2);
    step();
    do_reset();
    fill(4, 0); step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        fill_en           = 1'($urandom_range(0, 1));
        fill_set          = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
        access_en         = 1'($urandom_range(0, 1));
        access_set        = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
        access_update_en  = 1'($urandom_range(0, 1));
        access_update_way = 2'($urandom);
        step();
      end
    end
    idle_inputs();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_lru_tree.md
# cache_lru_tree

Tree pseudo-LRU replacement tracker for a set-associative cache. It is used by the L1 data and instruction cache tag stages. It keeps per-set recency state and tells the fill logic which way to replace. Pipeline accesses that hit mark a way most-recently-used; fills mark the victim way most-recently-used. All state is held in flops so it can be cleared by reset.

## Interface
- NUM_SETS, default 64: number of sets; any value ≥ 2.
- NUM_WAYS, default 4: associativity; must be 1, 2, 4 or 8.
- SET_INDEX_WIDTH, derived: $clog2(NUM_SETS).
- WAY_INDEX_WIDTH, derived: $clog2(NUM_WAYS), minimum 1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fill_en  in  1  a line fill is requested for fill_set.
- fill_set  in  SET_INDEX_WIDTH  set being filled.
- fill_way  out  WAY_INDEX_WIDTH  victim way for the fill issued the previous cycle.
- access_en  in  1  a pipeline access is looking up access_set.
- access_set  in  SET_INDEX_WIDTH  set being accessed.
- access_update_en  in  1  the access issued the previous cycle hit and should be marked MRU.
- access_update_way  in  WAY_INDEX_WIDTH  way that hit.

## Operation
- **Per-set state:** NUM_WAYS-1 tree bits, heap-ordered. Node 1 is the root; children of node n are 2n and 2n+1; the leaves are the ways in ascending order. NUM_WAYS=1 has no bits.
- **Bit meaning:** 0 means the LRU side is the lower half (left child); 1 means the upper half.
- **Victim selection:** start at the root and follow each bit down to a leaf. That leaf is the victim.
- **Touch of way w:** every node on w's path is set to point away from w. Bits not on the path are unchanged.
- **NUM_WAYS=2:** the single bit equals the victim way. A touch of way w writes !w.
- **Fill:**
  - When fill_en=1, latch fill_set and read that set's bits.
  - Next cycle, fill_way = victim of the latched bits.
  - At the end of that same cycle, the victim is touched.
- **Access:**
  - When access_en=1, latch access_set and read that set's bits.
  - If access_update_en=1 the next cycle, touch access_update_way in the latched set.
  - access_update_en with no access_en in the prior cycle applies to the most recently latched access set.
- **Collision:** if a fill touch and an access touch are due in the same cycle, the fill touch wins and the access touch is dropped. This holds for the same set or different sets.
- **Read-during-write bypass:** if a set is read in the cycle it is being written, the read returns the newly written bits. Any of these reads qualifies: fill read, access read, or both.
- **Idle inputs:** when fill_en=0, fill_set is don't-care. When access_en=0, access_set is don't-care.

## Timing
- **Reset:** while reset=0, all tree bits, latched sets, and the latched fill flag are 0, and fill_way=0. After reset, every set's victim is way 0.
- **Fill latency:** fill_en in cycle N → fill_way valid in cycle N+1 → bits written at the N+1/N+2 edge. Back-to-back fills to the same set in cycles N and N+1 return different ways (thanks to the bypass).
- **Access latency:** access_en in cycle N → access_update_en sampled in cycle N+1 → bits written at the N+1/N+2 edge.
- **Throughput:** one fill and one access may each start every cycle.
- **fill_way outside valid cycles:** holds the victim of the last latched fill set. Consumers use it only in the cycle after fill_en.
- **Reset mid-operation:** reset asserted at any time clears all state immediately. Pending updates are discarded.

## Test plan
- **Reset victims:** assert reset, release, fill_en on set 5 → fill_way=0 the next cycle. Then fill sets 0 and 63 → fill_way=0 for each.
- **Fill rotation (4 ways):** fill_en on set 3 for 5 consecutive cycles → fill_way sequence 0, 2, 1, 3, 0. This exercises the same-set bypass.
- **Hit then fill:** after reset, access_en on set 7, then access_update_en with way 0 → a later fill to set 7 gives way 2. Touching way 2 before the fill instead gives way 0.
- **Collision:** fill set 9 in cycle N, access set 9 in cycle N, access_update_en way 3 in cycle N+1 → fill_way=0 and only the fill touch applies. A subsequent fill to set 9 gives way 2.
- **Set isolation:** touch ways in set 1 only → fills to set 2 still return 0, 2, 1, 3.
- **Mid-stream reset / other geometries:** reset mid-stream → the next fill to a previously touched set returns 0. With NUM_WAYS=2 → fills alternate 0, 1. With NUM_WAYS=8 from reset → 0, 4, 2, 6, 1, 5, 3, 7.
